// File: rtl/subcarrier_bit_timer_pkg.sv
// Shared types and elaboration helpers for the subcarrier bit timer.
// Rate encoding plus cycles-per-bit and tick-counter sizing functions.
package subcarrier_pkg;

  typedef enum logic [1:0] {
    RATE_FC128 = 2'd0,
    RATE_FC64  = 2'd1,
    RATE_FC32  = 2'd2,
    RATE_FC16  = 2'd3
  } rate_t;

  // Rates beyond log2(max_cycles) would shift to zero; clamp to one cycle per bit.
  function automatic int cycles_per_bit(input int max_cycles, input int rate);
    int cpb;
    cpb = max_cycles >> rate;
    if (cpb < 1) cpb = 1;
    return cpb;
  endfunction

  function automatic int tick_width(input int half_period, input int max_cycles);
    return $clog2(2 * half_period * max_cycles);
  endfunction

endpackage

// File: rtl/subcarrier_bit_timer_if.sv
// Framing-side bundle of the subcarrier bit timer: request/rate/BPSK in, strobes out.
// master = tx framing logic, slave = timer.
interface subcarrier_bit_timer_if #(
  parameter int RATE_W = 2
);
  logic              en;
  logic [RATE_W-1:0] rate_sel;
  logic              bpsk_data;
  logic              subcarrier;
  logic              bit_start;
  logic              half_bit;
  logic              active;

  modport master (
    output en, rate_sel, bpsk_data,
    input  subcarrier, bit_start, half_bit, active
  );

  modport slave (
    input  en, rate_sel, bpsk_data,
    output subcarrier, bit_start, half_bit, active
  );
endinterface

// File: rtl/subcarrier_bit_timer.sv
// PICC->PCD subcarrier generator with bit timing; outputs one tick after en is seen idle.
// No backpressure: stops only at a bit boundary. SUBCARRIER_BPSK_EN adds per-bit BPSK phase.
module subcarrier_bit_timer
  import subcarrier_pkg::*;
#(
  parameter int HALF_PERIOD   = 8,
  parameter int MAX_SC_CYCLES = 8,
  parameter int RATE_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  subcarrier_bit_timer_if.slave sc_if
);

  localparam int TW     = tick_width(HALF_PERIOD, MAX_SC_CYCLES);
  localparam int CW     = TW + 1;
  localparam int HP_LSB = $clog2(HALF_PERIOD);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [TW-1:0]     t;
  logic [RATE_W-1:0] rate_q;
  logic [CW-1:0]     bit_ticks;
  logic              running;
  logic              last_tick;
  logic              start_bit;
  logic              phase;

  always_comb begin
    bit_ticks = CW'(2 * HALF_PERIOD * cycles_per_bit(MAX_SC_CYCLES, int'(rate_q)));
  end

  assign running   = (state == ST_RUN);
  assign last_tick = running && ({1'b0, t} == (bit_ticks - 1'b1));
  // en is only looked at when idle or on the final tick of a bit.
  assign start_bit = sc_if.en && ((state == ST_IDLE) || last_tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      t      <= '0;
      rate_q <= '0;
    end else if (start_bit) begin
      state <= ST_RUN;
      t     <= '0;
      if (state == ST_IDLE) rate_q <= sc_if.rate_sel;
    end else if (last_tick) begin
      state <= ST_IDLE;
      t     <= '0;
    end else if (running) begin
      t <= t + 1'b1;
    end
  end

`ifdef SUBCARRIER_BPSK_EN
  logic phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b1;
    end else if (start_bit) begin
      phase_q <= sc_if.bpsk_data;
    end
  end

  assign phase = phase_q;
`else
  logic unused_bpsk;
  assign unused_bpsk = sc_if.bpsk_data;
  assign phase       = 1'b1;
`endif

  // Bit HP_LSB of t flips every half-period; phase 0 starts each bit loaded.
  assign sc_if.subcarrier = running && (t[HP_LSB] ^ phase);
  assign sc_if.bit_start  = running && (t == '0);
  assign sc_if.half_bit   = running && ({1'b0, t} == (bit_ticks >> 1));
  assign sc_if.active     = running;

endmodule

// File: tb/tb_subcarrier_bit_timer.sv
// Directed bench for subcarrier_bit_timer: default instance plus a MAX_SC_CYCLES=4 clamp instance.
module tb_subcarrier_bit_timer;
  import subcarrier_pkg::*;

  localparam int HP = 8;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  en    = 1'b0;
  logic  sel_b = 1'b0;
  logic  bpsk  = 1'b1;
  rate_t rate  = RATE_FC128;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  subcarrier_bit_timer_if #(.RATE_W(2)) ifa ();
  subcarrier_bit_timer_if #(.RATE_W(2)) ifb ();

  assign ifa.en        = en & ~sel_b;
  assign ifa.rate_sel  = rate;
  assign ifa.bpsk_data = bpsk;
  assign ifb.en        = en & sel_b;
  assign ifb.rate_sel  = rate;
  assign ifb.bpsk_data = bpsk;

  subcarrier_bit_timer #(.HALF_PERIOD(HP), .MAX_SC_CYCLES(8), .RATE_W(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sc_if (ifa)
  );

  subcarrier_bit_timer #(.HALF_PERIOD(HP), .MAX_SC_CYCLES(4), .RATE_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sc_if (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {active, bit_start, half_bit, subcarrier} of the selected instance
  function automatic logic [3:0] outs();
    if (sel_b) return {ifb.active, ifb.bit_start, ifb.half_bit, ifb.subcarrier};
    return {ifa.active, ifa.bit_start, ifa.half_bit, ifa.subcarrier};
  endfunction

  // Expected outputs on cycle c (cycle 1 = first tick after en is seen idle).
  function automatic logic [3:0] expv(input int c, input int bit_len, input int nbits,
                                      input logic [7:0] pat);
    int   k;
    int   p;
    logic base;
    logic ph;
    if (c < 1 || c > nbits * bit_len) return 4'b0000;
    k    = (c - 1) / bit_len;
    p    = (c - 1) % bit_len;
    base = ((p / HP) % 2) == 0;
`ifdef SUBCARRIER_BPSK_EN
    ph = pat[k];
`else
    ph = 1'b1;
`endif
    return {1'b1, p == 0, p == bit_len / 2, ph ? base : !base};
  endfunction

  // Starts on a negedge with the DUT idle. en is held high on cycles in [a0,a1] or [b0,b1];
  // rate is changed to rs_val at cycle rs_cyc; bpsk follows pat per bit.
  task automatic run_seq(input string tag, input rate_t rs, input int bit_len, input int nbits,
                         input int a0, input int a1, input int b0, input int b1,
                         input int rs_cyc, input rate_t rs_val, input logic [7:0] pat);
    rate = rs;
    bpsk = pat[0];
    en   = 1'b1;
    for (int c = 1; c <= nbits * bit_len + 1; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, c), 32'(outs()), 32'(expv(c, bit_len, nbits, pat)));
      en = (c >= a0 && c <= a1) || (c >= b0 && c <= b1);
      if (c == rs_cyc) rate = rs_val;
      bpsk = pat[(c / bit_len) % 8];
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    check("reset_a", 32'(outs()), 32'h0);
    sel_b = 1'b1;
    check("reset_b", 32'(outs()), 32'h0);
    sel_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(outs()), 32'h0);

    // one-cycle en pulse, lowest rate
    run_seq("single_r0", RATE_FC128, 128, 1, 0, -1, 0, -1, 0, RATE_FC128, 8'hFF);
    // en held 40 cycles at fc/16 -> three back-to-back bits
    run_seq("held_r3", RATE_FC16, 16, 3, 1, 39, 0, -1, 0, RATE_FC128, 8'hFF);
    // mid-bit rate change and en glitch ignored; en at t=127 continues at the latched rate
    run_seq("midbit_r0", RATE_FC128, 128, 2, 60, 60, 128, 128, 30, RATE_FC32, 8'hFF);
    // BPSK phase per bit: 1,0,1
    run_seq("bpsk_r3", RATE_FC16, 16, 3, 1, 39, 0, -1, 0, RATE_FC128, 8'b0000_0101);

    // clamp: MAX_SC_CYCLES=4, rate 3 -> one subcarrier cycle per bit
    sel_b = 1'b1;
    run_seq("clamp_r3", RATE_FC16, 16, 1, 0, -1, 0, -1, 0, RATE_FC128, 8'hFF);
    sel_b = 1'b0;

    // async reset in the middle of a rate-1 bit
    rate = RATE_FC64;
    bpsk = 1'b1;
    en   = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 1) en = 1'b0;
    end
    check("pre_rst_t50", 32'(outs()), 32'(4'b1001));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_immediate", 32'(outs()), 32'h0);
    en = 1'b1;
    @(negedge clk);
    check("rst_held", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_c1", 32'(outs()), 32'(4'b1101));
    en = 1'b0;
    for (int c = 2; c <= 65; c++) begin
      @(negedge clk);
      check($sformatf("restart c%0d", c), 32'(outs()), 32'(expv(c, 64, 1, 8'hFF)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/subcarrier_bit_timer.md
Name: subcarrier_bit_timer

Overview:
Parametrised PICC→PCD subcarrier generator with integrated bit-period timing, for multiple bit rates (fc/128, fc/64, fc/32, fc/16).
- Produces the load-modulation subcarrier, plus bit_start and half_bit strobes for the Manchester/BPSK encoder.
- Stops only on a bit boundary, so no transmitted bit is ever truncated.
- Sits between the tx framing logic and the load modulator, clocked by the 13.56 MHz carrier clock.

Parameters:
- HALF_PERIOD, 8: clk ticks per subcarrier half-period (8 gives fc/16). Power of 2, at least 2.
- MAX_SC_CYCLES, 8: subcarrier cycles per bit at the lowest rate (rate_sel=0). Power of 2, at least 1.
- RATE_W, 2: width of rate_sel.

Ports:
- clk  in  1  13.56 MHz carrier clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  request transmission; sampled only when idle and on the last tick of each bit
- rate_sel  in  RATE_W  subcarrier cycles per bit = MAX_SC_CYCLES >> rate_sel
- bpsk_data  in  1  bit value for the BPSK phase; used only with SUBCARRIER_BPSK_EN
- subcarrier  out  1  1 = loaded
- bit_start  out  1  one-cycle pulse on the first tick of every bit
- half_bit  out  1  one-cycle pulse on the first tick of the second half of every bit
- active  out  1  high while a bit period is in progress

Behaviour:
- Reset (async, immediate, also mid-bit): subcarrier=0, bit_start=0, half_bit=0, active=0; counters 0; state IDLE.
- Derived values:
  - CPB = MAX_SC_CYCLES >> rate_sel, clamped to a minimum of 1 if rate_sel exceeds log2(MAX_SC_CYCLES).
  - BIT_TICKS = 2*HALF_PERIOD*CPB (128/64/32/16 at defaults).
  - Tick counter t has width clog2(2*HALF_PERIOD*MAX_SC_CYCLES).
- States:
  - IDLE: all outputs 0. If en=1 at the clock edge, latch rate_sel and move to RUN with t=0. The next cycle shows active=1, bit_start=1 and subcarrier=1 (one tick latency from en).
  - RUN, tick counting:
    - t increments every clk.
    - subcarrier is 1 at t=0 and toggles whenever (t mod HALF_PERIOD)==0 and t≠0. Each bit therefore starts loaded and contains CPB full subcarrier cycles.
    - half_bit=1 when t==BIT_TICKS/2.
    - bit_start=1 when t==0.
  - RUN, bit boundary (t==BIT_TICKS-1): sample en.
    - en=1: wrap to t=0, next bit begins, bit_start pulses next cycle. rate_sel is NOT re-latched.
    - en=0: return to IDLE, all outputs 0 next cycle.
- en changes in the middle of a bit are ignored, including a deassert/reassert pulse.
- rate_sel changes while active are ignored until the next IDLE→RUN transition.
- bit_start and half_bit are never high in the same cycle (BIT_TICKS ≥ 4).
- If en is held high, bits are back-to-back with no gap ticks.

Optional Feature:
- Macro: SUBCARRIER_BPSK_EN.
- Defined:
  - bpsk_data is sampled on each edge that starts a bit (IDLE→RUN or wrap).
  - bpsk_data=1: phase 0, bit starts loaded.
  - bpsk_data=0: phase 180°, subcarrier inverted for the whole bit, bit starts unloaded.
  - Phase holds constant within a bit.
- Undefined:
  - bpsk_data is ignored and phase is always 0.
  - The port is still present; a tie-off is allowed.

Decomposition:
- Package subcarrier_pkg:
  - enum rate_t: RATE_FC128=0, RATE_FC64, RATE_FC32, RATE_FC16.
  - function cycles_per_bit(max, rate).
  - localparam function for the tick counter width.
- No sub-module: one FSM plus one counter fits in a single module.

Test Plan:
- Defaults, rate_sel=0, en pulsed high 1 cycle while idle → active for exactly 128 cycles. bit_start at cycle 1 only, half_bit at cycle 65, subcarrier pattern 1×8,0×8 repeated 8 times, then all outputs 0.
- rate_sel=3, en held high for 40 cycles → 3 bits of 16 ticks (en still high at the boundaries at cycles 16 and 32; sampled low at 48). bit_start at 1, 17, 33; half_bit at 9, 25, 41; active drops after cycle 48.
- rate_sel changed 0→2 mid-bit, and en toggled 0→1 mid-bit → no effect; bit length stays 128, and continuation is decided solely by en at t=127.
- rst_n asserted at t=50 of a rate 1 bit → all outputs 0 immediately. After release with en=1 → clean restart, bit_start one tick later.
- SUBCARRIER_BPSK_EN, rate_sel=3, bpsk_data=1,0,1 on successive bit boundaries → subcarrier 1×8,0×8 / 0×8,1×8 / 1×8,0×8. Without the macro → all three bits are 1×8,0×8.
- rate_sel=3 with MAX_SC_CYCLES=4 (clamp) → CPB=1, BIT_TICKS=16, no counter underflow.
